// File: rtl/mod17_pkg.sv
// Shared constants and the tag record carried alongside the mod-17 divider pipeline.
package mod17_pkg;

   localparam int unsigned DIV_W         = 32;
   localparam int unsigned REM_W         = 5;
   localparam int unsigned MOD17_LATENCY = 14;
   localparam int unsigned STAT_W        = 16;
   localparam int unsigned MAX_TAG_W     = 4;

   // idx is wide enough for 16 requesters; narrower configs zero-extend
   typedef struct packed {
      logic                 valid;
      logic [MAX_TAG_W-1:0] idx;
   } tag_t;

endpackage

// File: rtl/mod17_rr_arbiter.sv
// Round-robin grant over N_REQ requesters; the pointer holds the last granted index
// and moves only when the caller strobes update_i.
module mod17_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_REQ-1:0] req_i,
   input  logic             block_i,
   input  logic             update_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      cand      = '0;
      // search starts one past the last winner and wraps
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((32'(ptr_q) + k) % N_REQ);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            gnt_idx_o   = cand;
         end
      end
      if (block_i) begin
         gnt_o = '0;
      end
      ptr_d = update_i ? gnt_idx_o : ptr_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= IDX_W'(N_REQ - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mod17_rr_scheduler.sv
// Shares one mod-17 divider among N_REQ requesters and routes remainders back by tag.
// Optional per-requester/drop counters are built when MOD17_SCHED_STATS_EN is defined.
module mod17_rr_scheduler
   import mod17_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned LATENCY = MOD17_LATENCY
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*DIV_W-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   mark_in,
   output logic [DIV_W-1:0]       divident,
   input  logic                   mark_out,
   input  logic [REM_W-1:0]       reminder,
   output logic [N_REQ-1:0]       res_valid,
   output logic [REM_W-1:0]       res_reminder,
   output logic                   err_sync
`ifdef MOD17_SCHED_STATS_EN
   ,
   output logic [N_REQ*STAT_W-1:0] issue_cnt,
   output logic [STAT_W-1:0]       drop_cnt
`endif
);

   localparam int unsigned TAG_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   // stage 0 sits beside mark_in; the last stage lines up with mark_out
   localparam int unsigned DEPTH   = LATENCY + 2;
   localparam int unsigned BLANK_W = $clog2(LATENCY + 2);

   logic [N_REQ-1:0] gnt;
   logic [TAG_W-1:0] gnt_idx;
   logic             xfer, blanking, block;

   logic               mark_in_q, mark_in_d;
   logic [DIV_W-1:0]   divident_q, divident_d;
   logic [N_REQ-1:0]   res_valid_q, res_valid_d;
   logic [REM_W-1:0]   res_rem_q, res_rem_d;
   logic               err_q, err_d;
   logic [BLANK_W-1:0] blank_q, blank_d;
   tag_t               tag_q [DEPTH];
   tag_t               tag_d [DEPTH];
   tag_t               tag_out;

   assign blanking = (blank_q != '0);
   assign block    = rst | blanking;
   assign xfer     = |gnt;

   mod17_rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (TAG_W)
   ) u_arb (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req_valid),
      .block_i   (block),
      .update_i  (xfer),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   always_comb begin
      mark_in_d  = xfer;
      divident_d = divident_q;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (gnt[i]) begin
            divident_d = req_data[i*DIV_W +: DIV_W];
         end
      end

      tag_d[0] = '0;
      if (xfer) begin
         tag_d[0].valid = 1'b1;
         tag_d[0].idx   = MAX_TAG_W'(gnt_idx);
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
         tag_d[i] = tag_q[i-1];
      end
      tag_out = tag_q[DEPTH-1];

      blank_d     = blanking ? blank_q - 1'b1 : blank_q;
      res_valid_d = '0;
      res_rem_d   = mark_out ? reminder : res_rem_q;
      err_d       = err_q;
      // divider output is untrusted until everything sampled before reset has drained
      if (!blanking) begin
         if (mark_out) begin
            res_valid_d = N_REQ'(1) << tag_out.idx;
         end
         if (mark_out != tag_out.valid) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mark_in_q   <= 1'b0;
         divident_q  <= '0;
         res_valid_q <= '0;
         res_rem_q   <= '0;
         err_q       <= 1'b0;
         blank_q     <= BLANK_W'(LATENCY + 1);
         for (int i = 0; i < int'(DEPTH); i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         mark_in_q   <= mark_in_d;
         divident_q  <= divident_d;
         res_valid_q <= res_valid_d;
         res_rem_q   <= res_rem_d;
         err_q       <= err_d;
         blank_q     <= blank_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign req_ready    = gnt;
   assign mark_in      = mark_in_q;
   assign divident     = divident_q;
   assign res_valid    = res_valid_q;
   assign res_reminder = res_rem_q;
   assign err_sync     = err_q;

`ifdef MOD17_SCHED_STATS_EN
   logic [STAT_W-1:0] issue_q [N_REQ];
   logic [STAT_W-1:0] issue_d [N_REQ];
   logic [STAT_W-1:0] drop_q, drop_d;

   always_comb begin
      for (int i = 0; i < int'(N_REQ); i++) begin
         issue_d[i] = gnt[i] ? issue_q[i] + 1'b1 : issue_q[i];
         issue_cnt[i*STAT_W +: STAT_W] = issue_q[i];
      end
      drop_d = drop_q;
      if (!blanking && mark_out && !tag_out.valid && (drop_q != '1)) begin
         drop_d = drop_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= '0;
         for (int i = 0; i < int'(N_REQ); i++) begin
            issue_q[i] <= '0;
         end
      end else begin
         drop_q <= drop_d;
         for (int i = 0; i < int'(N_REQ); i++) begin
            issue_q[i] <= issue_d[i];
         end
      end
   end

   assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_mod17_rr_scheduler.sv
// Scoreboard bench for mod17_rr_scheduler with a behavioural mod-17 divider model.
module tb_mod17_rr_scheduler;

   localparam int N = 4;
   localparam int L = 14;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*32-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            mark_in;
   logic [31:0]     divident;
   logic            mark_out;
   logic [4:0]      reminder;
   logic [N-1:0]    res_valid;
   logic [4:0]      res_reminder;
   logic            err_sync;
`ifdef MOD17_SCHED_STATS_EN
   logic [N*16-1:0] issue_cnt;
   logic [15:0]     drop_cnt;
`endif

   always #5 clk = ~clk;

   mod17_rr_scheduler #(
      .N_REQ   (N),
      .LATENCY (L)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .mark_in      (mark_in),
      .divident     (divident),
      .mark_out     (mark_out),
      .reminder     (reminder),
      .res_valid    (res_valid),
      .res_reminder (res_reminder),
      .err_sync     (err_sync)
`ifdef MOD17_SCHED_STATS_EN
      ,
      .issue_cnt    (issue_cnt),
      .drop_cnt     (drop_cnt)
`endif
   );

   // Divider model: samples mark_in/dividend, presents them L+1 edges later.
   logic       m_pipe [L+1];
   logic [4:0] r_pipe [L+1];
   logic       force_mark = 1'b0;

   always @(posedge clk) begin
      m_pipe[0] <= mark_in;
      r_pipe[0] <= 5'(divident % 17);
      for (int i = 1; i <= L; i++) begin
         m_pipe[i] <= m_pipe[i-1];
         r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign mark_out = force_mark | m_pipe[L];
   assign reminder = force_mark ? 5'd9 : r_pipe[L];

   typedef struct {
      int       owner;
      logic [4:0] rem;
      int       issue;
      bit       chk_lat;
   } exp_t;

   exp_t sb[$];
   exp_t got;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   ptr;
   int   blank_left;
   int   iss_cnt [N];
   int   res_cnt [N];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every strobe must match the oldest outstanding issue.
   always @(negedge clk) begin
      if (res_valid !== '0) begin
         for (int i = 0; i < N; i++) if (res_valid[i]) res_cnt[i]++;
         if (sb.size() == 0) begin
            check("unexpected_result", 64'(res_valid), 64'd0);
         end else begin
            got = sb.pop_front();
            check("res_owner", 64'(res_valid), 64'(1) << got.owner);
            check("res_rem", 64'(res_reminder), 64'(got.rem));
            if (got.chk_lat) check("res_latency", 64'(cyc - got.issue), 64'(L + 2));
         end
      end
   end

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 1; k <= N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic clear_model();
      blank_left = L + 1;
      ptr        = N - 1;
      sb.delete();
      for (int i = 0; i < N; i++) begin
         iss_cnt[i] = 0;
         res_cnt[i] = 0;
      end
   endtask

   // One clock of stimulus; predicts grant, checks it, queues the expected result.
   task automatic drive(input logic [N-1:0] v, input logic [N*32-1:0] d);
      int g;
      logic [N-1:0] exp_rdy;
      req_valid = v;
      req_data  = d;
      @(negedge clk);
      g = (rst || blank_left > 0) ? -1 : rr_pick(v, ptr);
      exp_rdy = (g < 0) ? '0 : (N'(1) << g);
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (g >= 0) begin
         sb.push_back('{g, 5'(d[g*32 +: 32] % 17), cyc + 1, 1'b1});
         ptr = g;
         iss_cnt[g]++;
      end
      @(posedge clk);
      #1;
      if (rst) clear_model();
      else if (blank_left > 0) blank_left--;
   endtask

   task automatic do_reset(input logic [N-1:0] v);
      rst = 1'b1;
      drive(v, req_data);
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive('0, req_data);
   endtask

   task automatic wait_blank();
      while (blank_left > 0) drive('0, req_data);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N*32-1:0] d;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      clear_model();
      do_reset('0);
      rst = 1'b1;
      do_reset('0);
      check("reset_mark_in", 64'(mark_in), 64'd0);
      check("reset_divident", 64'(divident), 64'd0);
      check("reset_res_valid", 64'(res_valid), 64'd0);
      check("reset_res_rem", 64'(res_reminder), 64'd0);
      check("reset_err", 64'(err_sync), 64'd0);
      wait_blank();

      // single request from requester 0
      drive(4'b0001, {96'd0, 32'd17});
      check("issue_mark_in", 64'(mark_in), 64'd1);
      check("issue_divident", 64'(divident), 64'd17);
      idle(20);

      // all four requesters, continuous
      d = {32'd45642458, 32'hFFFF_FFFE, 32'd294967295, 32'hFFFF_FFFF};
      for (int i = 0; i < 8; i++) drive(4'hF, d);
      idle(20);

      // requesters 1 and 3 only
      d = {32'd18, 32'd0, 32'd687452345, 32'd0};
      for (int i = 0; i < 4; i++) drive(4'b1010, d);
      idle(20);

      // reset with 10 results in flight
      for (int i = 0; i < 10; i++) drive(4'hF, {$urandom, $urandom, $urandom, $urandom});
      do_reset(4'hF);
      for (int i = 0; i < 16; i++) drive(4'hF, {$urandom, $urandom, $urandom, $urandom});
      idle(20);
      check("err_after_reset_flush", 64'(err_sync), 64'd0);
      check("sb_empty_after_flush", 64'(sb.size()), 64'd0);

      // spurious divider mark with no matching issue
      force_mark = 1'b1;
      sb.push_back('{0, 5'd9, 0, 1'b0});
      @(posedge clk);
      #1;
      force_mark = 1'b0;
      check("err_set", 64'(err_sync), 64'd1);
      idle(30);
      check("err_sticky", 64'(err_sync), 64'd1);
`ifdef MOD17_SCHED_STATS_EN
      check("drop_cnt", 64'(drop_cnt), 64'd1);
`endif
      do_reset('0);
      check("err_cleared", 64'(err_sync), 64'd0);
      wait_blank();

      // randomized traffic
      for (int i = 0; i < 5000; i++) begin
         drive(N'($urandom_range(0, (1 << N) - 1)), {$urandom, $urandom, $urandom, $urandom});
      end
      idle(20);
      check("sb_drained", 64'(sb.size()), 64'd0);
      check("err_random", 64'(err_sync), 64'd0);
      for (int i = 0; i < N; i++) begin
         check($sformatf("res_count_%0d", i), 64'(res_cnt[i]), 64'(iss_cnt[i]));
`ifdef MOD17_SCHED_STATS_EN
         check($sformatf("issue_cnt_%0d", i), 64'(issue_cnt[i*16 +: 16]), 64'(iss_cnt[i] % 65536));
`endif
      end
`ifdef MOD17_SCHED_STATS_EN
      check("drop_cnt_random", 64'(drop_cnt), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
